// File: rtl/move_key_gen.sv
// move_key_gen: turns four raw active-low push-buttons into debounced,
// auto-repeating one-cycle move strobes for a cursor mover.
//
// Ports:
//   clk     - single clock, rising edge
//   rst     - synchronous active-high reset
//   btn     - [3:0] raw asynchronous buttons, active-low
//             bit0 = left (x-1), bit3 = right (x+1), bit1 = down (y+1), bit2 = up (y-1)
//   move    - [3:0] registered active-low one-cycle move strobes, same mapping as btn
//   pressed - [3:0] registered active-high debounced held level per button
//
// Parameters:
//   DEB_CYC    - stable synchronized cycles needed to accept a press or a release
//   RPT_DELAY  - cycles from the first move pulse to the first auto-repeat pulse
//   RPT_PERIOD - cycles between auto-repeat pulses (0 disables auto-repeat)
module move_key_gen #(
  parameter int DEB_CYC    = 1000000,
  parameter int RPT_DELAY  = 25000000,
  parameter int RPT_PERIOD = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  output logic [3:0] move,
  output logic [3:0] pressed
);

  localparam int RMAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int DW   = $clog2(DEB_CYC) + 1;
  localparam int RW   = $clog2(RMAX) + 1;

  // Counters compare against "last value before the threshold" so the
  // transition happens on the edge where the count would reach it.
  localparam logic [DW-1:0] DEB_LAST = DW'((DEB_CYC <= 1) ? 0 : DEB_CYC - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'((RPT_DELAY <= 1) ? 0 : RPT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'((RPT_PERIOD <= 1) ? 0 : RPT_PERIOD - 1);
  localparam bit            RPT_EN   = (RPT_PERIOD != 0);

  logic [3:0] sync1, sync2;
  logic [3:0] pulse;
  logic [3:0] press_nxt;
  logic [3:0] opp;
  logic [3:0] fire;

  // Stage 0: two-flop synchronizer, idle value = released (1)
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 4'b1111;
      sync2 <= 4'b1111;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_btn
    typedef enum logic [1:0] {IDLE, ARM, DELAY, REPEAT} state_t;

    state_t        state, state_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [RW-1:0] rcnt, rcnt_n;
    logic          pulse_i;
    logic          press_i;
    logic          released;

    always_ff @(posedge clk) begin
      if (rst) begin
        state <= IDLE;
        dcnt  <= '0;
        rcnt  <= '0;
      end else begin
        state <= state_n;
        dcnt  <= dcnt_n;
        rcnt  <= rcnt_n;
      end
    end

    always_comb begin
      state_n  = state;
      dcnt_n   = dcnt;
      rcnt_n   = rcnt;
      pulse_i  = 1'b0;
      press_i  = pressed[i];
      released = 1'b0;
      case (state)
        IDLE: begin
          dcnt_n = '0;
          rcnt_n = '0;
          if (!sync2[i]) begin
            if (DEB_CYC <= 1) begin
              state_n = DELAY;
              pulse_i = 1'b1;
              press_i = 1'b1;
            end else begin
              state_n = ARM;
              dcnt_n  = DW'(1);
            end
          end
        end
        ARM: begin
          if (sync2[i]) begin
            state_n = IDLE;
            dcnt_n  = '0;
          end else if (dcnt == DEB_LAST) begin
            state_n = DELAY;
            dcnt_n  = '0;
            rcnt_n  = '0;
            pulse_i = 1'b1;
            press_i = 1'b1;
          end else begin
            dcnt_n = dcnt + DW'(1);
          end
        end
        default: begin
          // DELAY / REPEAT: the release debounce runs alongside repeat timing;
          // a completed release takes priority over a coincident repeat pulse.
          if (sync2[i]) begin
            if (dcnt == DEB_LAST) begin
              released = 1'b1;
              state_n  = IDLE;
              dcnt_n   = '0;
              rcnt_n   = '0;
              press_i  = 1'b0;
            end else begin
              dcnt_n = dcnt + DW'(1);
            end
          end else begin
            dcnt_n = '0;
          end
          if (!released && RPT_EN) begin
            if (state == DELAY) begin
              if (rcnt == DLY_LAST) begin
                state_n = REPEAT;
                rcnt_n  = '0;
                pulse_i = 1'b1;
              end else begin
                rcnt_n = rcnt + RW'(1);
              end
            end else begin
              if (rcnt == PER_LAST) begin
                rcnt_n  = '0;
                pulse_i = 1'b1;
              end else begin
                rcnt_n = rcnt + RW'(1);
              end
            end
          end
        end
      endcase
    end

    assign pulse[i]     = pulse_i;
    assign press_nxt[i] = press_i;
  end

  // Opposing directions cancel each other (left/right, up/down); a strobe
  // is also suppressed right after one so a bit is never low twice in a row.
  assign opp  = {pulse[0], pulse[1], pulse[2], pulse[3]};
  assign fire = pulse & ~opp & move;

  // Stage 1: registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      move    <= 4'b1111;
      pressed <= 4'b0000;
    end else begin
      move    <= ~fire;
      pressed <= press_nxt;
    end
  end

endmodule

// File: tb/tb_move_key_gen.sv
module tb_move_key_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] btn2;
  logic [3:0] move, move2;
  logic [3:0] pressed, pressed2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  move_key_gen #(.DEB_CYC(4), .RPT_DELAY(16), .RPT_PERIOD(8)) dut (
    .clk(clk), .rst(rst), .btn(btn), .move(move), .pressed(pressed)
  );

  move_key_gen #(.DEB_CYC(4), .RPT_DELAY(16), .RPT_PERIOD(0)) dut_norpt (
    .clk(clk), .rst(rst), .btn(btn2), .move(move2), .pressed(pressed2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse schedule for a press accepted at edge 6 with RPT_DELAY=16, RPT_PERIOD=8.
  function automatic bit is_rep(input int e);
    return (e == 6) || (e >= 22 && ((e - 22) % 8) == 0);
  endfunction

  task automatic do_reset();
    rst  = 1'b1;
    btn  = 4'b1111;
    btn2 = 4'b1111;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    btn  = 4'b0000;
    btn2 = 4'b0000;
    for (int k = 0; k < 3; k++) step();
    total++;
    if (move !== 4'b1111) begin
      bad++; $display("FAIL reset_move got=%b exp=1111", move);
    end
    total++;
    if (pressed !== 4'b0000) begin
      bad++; $display("FAIL reset_pressed got=%b exp=0000", pressed);
    end
    total++;
    if (move2 !== 4'b1111 || pressed2 !== 4'b0000) begin
      bad++; $display("FAIL reset_norpt got=%b/%b exp=1111/0000", move2, pressed2);
    end
    do_reset();
  endtask

  task automatic test_press_repeat();
    logic [3:0] em, ep;
    do_reset();
    btn = 4'b1110;
    for (int e = 1; e <= 40; e++) begin
      step();
      em = is_rep(e) ? 4'b1110 : 4'b1111;
      ep = (e >= 6) ? 4'b0001 : 4'b0000;
      total++;
      if (move !== em) begin
        bad++; $display("FAIL press_move e=%0d got=%b exp=%b", e, move, em);
      end
      total++;
      if (pressed !== ep) begin
        bad++; $display("FAIL press_pressed e=%0d got=%b exp=%b", e, pressed, ep);
      end
    end
  endtask

  task automatic test_short_glitch();
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      btn = ((e >= 1 && e <= 3) || (e >= 5 && e <= 7)) ? 4'b0111 : 4'b1111;
      step();
      total++;
      if (move !== 4'b1111 || pressed !== 4'b0000) begin
        bad++; $display("FAIL glitch_press e=%0d got=%b/%b exp=1111/0000", e, move, pressed);
      end
    end
  endtask

  task automatic test_release_bounce();
    logic [3:0] em, ep;
    do_reset();
    for (int e = 1; e <= 34; e++) begin
      if (e <= 6)       btn = 4'b1101;
      else if (e <= 18) btn = (((e - 7) % 3) == 2) ? 4'b1101 : 4'b1111;
      else              btn = 4'b1111;
      step();
      em = (e == 6 || e == 22) ? 4'b1101 : 4'b1111;
      ep = (e >= 6 && e < 24) ? 4'b0010 : 4'b0000;
      total++;
      if (move !== em) begin
        bad++; $display("FAIL release_move e=%0d got=%b exp=%b", e, move, em);
      end
      total++;
      if (pressed !== ep) begin
        bad++; $display("FAIL release_pressed e=%0d got=%b exp=%b", e, pressed, ep);
      end
    end
  endtask

  task automatic test_opposing();
    logic [3:0] em;
    do_reset();
    btn = 4'b0110;
    for (int e = 1; e <= 40; e++) begin
      step();
      total++;
      if (move !== 4'b1111) begin
        bad++; $display("FAIL opposing_move e=%0d got=%b exp=1111", e, move);
      end
      if (e == 6 || e == 40) begin
        total++;
        if (pressed !== 4'b1001) begin
          bad++; $display("FAIL opposing_pressed e=%0d got=%b exp=1001", e, pressed);
        end
      end
    end
    do_reset();
    btn = 4'b1010;
    for (int e = 1; e <= 32; e++) begin
      step();
      em = is_rep(e) ? 4'b1010 : 4'b1111;
      total++;
      if (move !== em) begin
        bad++; $display("FAIL left_up_move e=%0d got=%b exp=%b", e, move, em);
      end
    end
    do_reset();
    btn = 4'b1100;
    for (int e = 1; e <= 8; e++) begin
      step();
      em = (e == 6) ? 4'b1100 : 4'b1111;
      total++;
      if (move !== em) begin
        bad++; $display("FAIL left_down_move e=%0d got=%b exp=%b", e, move, em);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] em, ep;
    do_reset();
    btn = 4'b1011;
    for (int e = 1; e <= 30; e++) begin
      rst = (e == 10);
      step();
      em = (e == 6 || e == 16) ? 4'b1011 : 4'b1111;
      ep = ((e >= 6 && e < 10) || e >= 16) ? 4'b0100 : 4'b0000;
      total++;
      if (move !== em) begin
        bad++; $display("FAIL rst_mid_move e=%0d got=%b exp=%b", e, move, em);
      end
      total++;
      if (pressed !== ep) begin
        bad++; $display("FAIL rst_mid_pressed e=%0d got=%b exp=%b", e, pressed, ep);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_no_repeat();
    logic [3:0] em;
    int npulse;
    do_reset();
    npulse = 0;
    btn2 = 4'b1101;
    for (int e = 1; e <= 100; e++) begin
      step();
      if (move2 !== 4'b1111) npulse++;
      em = (e == 6) ? 4'b1101 : 4'b1111;
      total++;
      if (move2 !== em) begin
        bad++; $display("FAIL norpt_move e=%0d got=%b exp=%b", e, move2, em);
      end
    end
    total++;
    if (npulse != 1) begin
      bad++; $display("FAIL norpt_count got=%0d exp=1", npulse);
    end
    total++;
    if (pressed2 !== 4'b0010) begin
      bad++; $display("FAIL norpt_pressed got=%b exp=0010", pressed2);
    end
  endtask

  initial begin
    rst  = 1'b1;
    btn  = 4'b1111;
    btn2 = 4'b1111;
    test_reset();
    test_press_repeat();
    test_short_glitch();
    test_release_bounce();
    test_opposing();
    test_reset_mid();
    test_no_repeat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
